mult_div_unit: RTL

- Iterative 32-bit integer multiply/divide engine that sits in the datapath beside the ALU.
- Fed by the sequence controller (mult_start/div_start) and by the register-file read ports (Reg1_Out/Reg2_Out as operands).
- Produces HI/LO results plus the mult_div_done pulse, which the controller consumes before asserting hi_EN/lo_EN.
- Implements MULT/MULTU/DIV/DIVU semantics using shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div_sign_fix.sv | 31 +++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // Fill bit for the quotient reported on a divide by zero (all ones).
  localparam bit DZ_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the sequence controller and the multiply/divide engine.
interface mult_div_if #(
  parameter int WIDTH = mult_div_pkg::WIDTH_DEF
);
  logic             mult_start;
  logic             div_start;
  logic             SIGNED;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic [WIDTH-1:0] HI_OUT;
  logic [WIDTH-1:0] LO_OUT;
  logic             mult_div_done;
  logic             BUSY;
  logic             DZ_OUT;

  modport master (
    output mult_start, div_start, SIGNED, OP_A, OP_B,
    input  HI_OUT, LO_OUT, mult_div_done, BUSY, DZ_OUT
  );

  modport slave (
    input  mult_start, div_start, SIGNED, OP_A, OP_B,
    output HI_OUT, LO_OUT, mult_div_done, BUSY, DZ_OUT
  );
endinterface

// File: rtl/mult_div_sign_fix.sv
// Turns the unsigned magnitude result into the signed HI/LO pair:
// product negated on sign mismatch, quotient likewise, remainder follows the dividend.
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               is_div,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic               flip;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    flip = neg_a ^ neg_b;
    prod = flip  ? -raw : raw;
    quo  = flip  ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    rem  = neg_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    hi   = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    lo   = is_div ? quo : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// operating on magnitudes with the sign applied once in FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       CLK,
  input logic       RST,
  mult_div_if.slave bus
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               neg_a, neg_b, is_div, dz_pend;

  logic               start_mul, start_div, op_b_zero, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, div_rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign start_mul = bus.mult_start;
  assign start_div = bus.div_start & ~bus.mult_start;
  assign op_b_zero = (bus.OP_B == '0);
  assign in_neg_a  = bus.SIGNED & bus.OP_A[WIDTH-1];
  assign in_neg_b  = bus.SIGNED & bus.OP_B[WIDTH-1];
  assign mag_a     = in_neg_a ? -bus.OP_A : bus.OP_A;
  assign mag_b     = in_neg_b ? -bus.OP_B : bus.OP_B;

  assign addend    = acc[0] ? opnd : '0;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Remainder shifted left with the next dividend bit; the difference always fits W bits when taken.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];

  assign bus.BUSY  = (state != IDLE);

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div (is_div),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .raw    (acc),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_mul)      state_nx = MUL;
        else if (start_div) state_nx = op_b_zero ? FIX : DIV;
      end
      MUL, DIV: if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:      state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt               <= '0;
      acc               <= '0;
      opnd              <= '0;
      neg_a             <= 1'b0;
      neg_b             <= 1'b0;
      is_div            <= 1'b0;
      dz_pend           <= 1'b0;
      bus.HI_OUT        <= '0;
      bus.LO_OUT        <= '0;
      bus.DZ_OUT        <= 1'b0;
      bus.mult_div_done <= 1'b0;
    end else begin
      bus.mult_div_done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (start_mul || start_div) begin
            neg_a      <= in_neg_a;
            neg_b      <= in_neg_b;
            is_div     <= ~start_mul;
            dz_pend    <= start_div & op_b_zero;
            cnt        <= CNT_W'(WIDTH);
            bus.DZ_OUT <= 1'b0;
            if (start_mul) begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end else if (op_b_zero) begin
              // Divide by zero reports the raw dividend and an all-ones quotient.
              acc  <= {bus.OP_A, {WIDTH{DZ_FILL}}};
              opnd <= '0;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
        end
        DIV: begin
          acc <= {div_rem, acc[WIDTH-2:0], div_ge};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          bus.HI_OUT <= dz_pend ? acc[2*WIDTH-1:WIDTH] : fix_hi;
          bus.LO_OUT <= dz_pend ? acc[WIDTH-1:0]       : fix_lo;
          bus.DZ_OUT <= dz_pend;
        end
        default: ;
      endcase
    end
  end

endmodule
